multitrack_note_sequencer: RTL and testbench

//  Parametrised multi-track successor to the single-track beat recorder.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_track_ram.sv | 27 ++
 rtl/multitrack_note_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_multitrack_note_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multi-track note sequencer: FSM encodings,
// default pitch constants and edit-direction bit positions.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECORD = 3'd1,
    ST_PLAY   = 3'd2,
    ST_STOP   = 3'd3,
    ST_EDIT   = 3'd4
  } seq_state_t;

  localparam int DEF_PITCH_W   = 6;
  localparam int DEF_MAX_PITCH = 47;
  localparam int DEF_REST      = 63;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

endpackage

// File: rtl/seq_track_ram.sv
// One track of pitch storage: a single write port plus two synchronous read
// ports (playback and renderer view). Reads during a write return old data.
module seq_track_ram #(
  parameter int PITCH_W = 6,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [PITCH_W-1:0] wdata,
  input  logic               play_re,
  input  logic [ADDR_W-1:0]  play_addr,
  output logic [PITCH_W-1:0] play_data,
  input  logic [ADDR_W-1:0]  view_addr,
  output logic [PITCH_W-1:0] view_data
);

  logic [PITCH_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (play_re) play_data <= mem[play_addr];
    view_data <= mem[view_addr];
  end

endmodule

// File: rtl/multitrack_note_sequencer.sv
// Beat-driven multi-track recorder/player/step-editor. All sequencing advances
// on beat_tick; playback and view data come from per-track synchronous RAMs.
module multitrack_note_sequencer
  import seq_pkg::*;
#(
  parameter int TRACKS    = 2,
  parameter int PITCH_W   = DEF_PITCH_W,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10,
  parameter int MAX_PITCH = DEF_MAX_PITCH,
  parameter int REST      = DEF_REST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      beat_tick,
  input  logic                      rec_req,
  input  logic                      play_req,
  input  logic                      edit_req,
  input  logic                      clr_req,
  input  logic                      loop_en,
  input  logic [2:0]                trk_sel,
  input  logic [PITCH_W-1:0]        live_pitch,
  input  logic [3:0]                dir,
  input  logic                      select,
  input  logic [ADDR_W-1:0]         view_addr,
  output logic [PITCH_W-1:0]        view_pitch,
  output logic [2:0]                state,
  output logic [ADDR_W-1:0]         beat_num,
  output logic [PITCH_W-1:0]        cur_pitch,
  output logic [ADDR_W:0]           song_len,
  output logic [TRACKS*PITCH_W-1:0] play_pitch,
  output logic                      end_pulse
);

  localparam logic [ADDR_W-1:0]  LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [PITCH_W-1:0] REST_CODE = PITCH_W'(REST);
  localparam logic [PITCH_W-1:0] TOP_CODE  = PITCH_W'(MAX_PITCH);

  seq_state_t           state_q, state_nxt;
  logic [ADDR_W-1:0]    beat_num_q, beat_nxt;
  logic [PITCH_W-1:0]   cur_q, cur_nxt;
  logic [ADDR_W:0]      len_q [TRACKS];
  logic [ADDR_W:0]      len_nxt [TRACKS];
  logic [TRACKS-1:0]    vld_p1, vld_nxt;
  logic                 end_q, end_nxt;
  logic                 we, len_wr;
  logic [PITCH_W-1:0]   wdata;
  logic [ADDR_W:0]      len_val;
  logic [TRACKS-1:0]    sel_hot, in_song;
  logic                 trk_ok;
  logic [ADDR_W:0]      sel_len, song_len_c;
  logic [ADDR_W-1:0]    edit_lim;
  logic [2:0]           view_sel_p1;
  logic [PITCH_W-1:0]   play_rd [TRACKS];
  logic [PITCH_W-1:0]   view_rd [TRACKS];

  // Cursor step, saturating at 0 and at the edit limit; opposing bits cancel.
  function automatic logic [ADDR_W-1:0] move_cursor(input logic [ADDR_W-1:0] pos,
                                                     input logic [3:0] d,
                                                     input logic [ADDR_W-1:0] lim);
    logic [ADDR_W-1:0] r;
    r = pos;
    if (d[DIR_LEFT] && !d[DIR_RIGHT]) begin
      if (pos != '0) r = pos - ADDR_W'(1);
    end else if (d[DIR_RIGHT] && !d[DIR_LEFT]) begin
      if (pos < lim) r = pos + ADDR_W'(1);
    end
    return r;
  endfunction

  function automatic logic [PITCH_W-1:0] step_pitch(input logic [PITCH_W-1:0] p,
                                                     input logic [3:0] d);
    logic [PITCH_W-1:0] r;
    r = p;
    if (d[DIR_DOWN] && !d[DIR_UP]) begin
      if (p != '0) r = p - PITCH_W'(1);
    end else if (d[DIR_UP] && !d[DIR_DOWN]) begin
      if (p < TOP_CODE) r = p + PITCH_W'(1);
    end
    return r;
  endfunction

  always_comb begin
    sel_hot    = '0;
    sel_len    = '0;
    song_len_c = '0;
    in_song    = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (trk_sel == 3'(t)) begin
        sel_hot[t] = 1'b1;
        sel_len    = len_q[t];
      end
      if (len_q[t] > song_len_c) song_len_c = len_q[t];
      in_song[t] = {1'b0, beat_num_q} < len_q[t];
    end
    trk_ok   = |sel_hot;
    edit_lim = (sel_len > {1'b0, LAST}) ? LAST : sel_len[ADDR_W-1:0];
  end

  always_comb begin
    state_nxt = state_q;
    beat_nxt  = beat_num_q;
    cur_nxt   = cur_q;
    len_nxt   = len_q;
    vld_nxt   = vld_p1;
    end_nxt   = 1'b0;
    we        = 1'b0;
    wdata     = live_pitch;
    len_wr    = 1'b0;
    len_val   = '0;
    if (beat_tick) begin
      vld_nxt = '0;
      case (state_q)
        ST_IDLE: begin
          beat_nxt = '0;
          if (clr_req) begin
            len_wr  = trk_ok;
            len_val = '0;
          end else if (rec_req) begin
            state_nxt = ST_RECORD;
          end else if (edit_req) begin
            state_nxt = ST_EDIT;
          end else if (play_req) begin
            state_nxt = ST_PLAY;
          end
        end
        ST_RECORD: begin
          if (!rec_req) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
          end else begin
            we      = trk_ok;
            len_wr  = trk_ok;
            len_val = {1'b0, beat_num_q} + (ADDR_W+1)'(1);
            vld_nxt = in_song & ~sel_hot;
            if (beat_num_q == LAST) begin
              state_nxt = ST_IDLE;
              beat_nxt  = '0;
            end else begin
              beat_nxt = beat_num_q + ADDR_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (!play_req) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
          end else if (song_len_c == '0) begin
            state_nxt = ST_STOP;
          end else begin
            vld_nxt = in_song;
            if ({1'b0, beat_num_q} == song_len_c - (ADDR_W+1)'(1)) begin
              end_nxt = 1'b1;
              if (loop_en) beat_nxt = '0;
              else state_nxt = ST_STOP;
            end else begin
              beat_nxt = beat_num_q + ADDR_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (!play_req) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
          end
        end
        ST_EDIT: begin
          if (!edit_req) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
          end else begin
            we    = select && trk_ok;
            wdata = cur_q;
            if (select && trk_ok && ({1'b0, beat_num_q} == sel_len)) begin
              len_wr  = 1'b1;
              len_val = sel_len + (ADDR_W+1)'(1);
            end
            beat_nxt = move_cursor(beat_num_q, dir, edit_lim);
            cur_nxt  = step_pitch(cur_q, dir);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          beat_nxt  = '0;
        end
      endcase
    end
    if (len_wr) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (sel_hot[t]) len_nxt[t] = len_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_num_q <= '0;
      cur_q      <= '0;
      len_q      <= '{default: '0};
      vld_p1     <= '0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      beat_num_q <= beat_nxt;
      cur_q      <= cur_nxt;
      len_q      <= len_nxt;
      vld_p1     <= vld_nxt;
      end_q      <= end_nxt;
    end
  end

  // p1 stage: RAM read data and track select for the view port arrive together.
  always_ff @(posedge clk) begin
    view_sel_p1 <= trk_sel;
  end

  for (genvar g = 0; g < TRACKS; g++) begin : g_trk
    seq_track_ram #(
      .PITCH_W (PITCH_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W)
    ) u_ram (
      .clk       (clk),
      .we        (we && sel_hot[g] && !reset),
      .waddr     (beat_num_q),
      .wdata     (wdata),
      .play_re   (beat_tick),
      .play_addr (beat_num_q),
      .play_data (play_rd[g]),
      .view_addr (view_addr),
      .view_data (view_rd[g])
    );
  end

  // The last note of a one-shot song keeps sounding for its beat; STOP
  // silences the output from the following tick.
  always_comb begin
    for (int t = 0; t < TRACKS; t++) begin
      play_pitch[t*PITCH_W +: PITCH_W] = vld_p1[t] ? play_rd[t] : REST_CODE;
    end
  end

  always_comb begin
    view_pitch = REST_CODE;
    for (int t = 0; t < TRACKS; t++) begin
      if (view_sel_p1 == 3'(t)) view_pitch = view_rd[t];
    end
  end

  assign state     = state_q;
  assign beat_num  = beat_num_q;
  assign cur_pitch = cur_q;
  assign song_len  = song_len_c;
  assign end_pulse = end_q;

endmodule

// File: tb/tb_multitrack_note_sequencer.sv
// Scenario bench for multitrack_note_sequencer with a beat-level reference model
// and a randomized soak phase.
module tb_multitrack_note_sequencer;

  localparam int TRACKS    = 2;
  localparam int PITCH_W   = 6;
  localparam int DEPTH     = 1024;
  localparam int ADDR_W    = 10;
  localparam int MAX_PITCH = 47;
  localparam int REST      = 63;

  logic clk = 1'b0, reset = 1'b0, beat_tick = 1'b0;
  logic rec_req = 1'b0, play_req = 1'b0, edit_req = 1'b0, clr_req = 1'b0;
  logic loop_en = 1'b0, select = 1'b0;
  logic [2:0] trk_sel = '0;
  logic [PITCH_W-1:0] live_pitch = '0;
  logic [3:0] dir = '0;
  logic [ADDR_W-1:0] view_addr = '0;
  logic [PITCH_W-1:0] view_pitch, cur_pitch;
  logic [2:0] state;
  logic [ADDR_W-1:0] beat_num;
  logic [ADDR_W:0] song_len;
  logic [TRACKS*PITCH_W-1:0] play_pitch;
  logic end_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multitrack_note_sequencer #(
    .TRACKS(TRACKS), .PITCH_W(PITCH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .MAX_PITCH(MAX_PITCH), .REST(REST)
  ) dut (
    .clk(clk), .reset(reset), .beat_tick(beat_tick), .rec_req(rec_req),
    .play_req(play_req), .edit_req(edit_req), .clr_req(clr_req), .loop_en(loop_en),
    .trk_sel(trk_sel), .live_pitch(live_pitch), .dir(dir), .select(select),
    .view_addr(view_addr), .view_pitch(view_pitch), .state(state),
    .beat_num(beat_num), .cur_pitch(cur_pitch), .song_len(song_len),
    .play_pitch(play_pitch), .end_pulse(end_pulse)
  );

  // Reference model: song memory, lengths, mode and what each track sounds.
  int m_mem [TRACKS][DEPTH];
  bit m_wr  [TRACKS][DEPTH];
  int m_len [TRACKS];
  int m_play[TRACKS];
  int m_state, m_beat, m_cur, m_end, m_view;
  bit m_view_ok;

  function automatic int m_song_len();
    int s = 0;
    for (int t = 0; t < TRACKS; t++) if (m_len[t] > s) s = m_len[t];
    return s;
  endfunction

  function automatic logic [TRACKS*PITCH_W-1:0] m_pp();
    logic [TRACKS*PITCH_W-1:0] v;
    for (int t = 0; t < TRACKS; t++) v[t*PITCH_W +: PITCH_W] = PITCH_W'(m_play[t]);
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_beat = 0; m_cur = 0; m_end = 0;
    for (int t = 0; t < TRACKS; t++) begin m_len[t] = 0; m_play[t] = REST; end
  endtask

  task automatic model_tick();
    int sel, lim, sl;
    bit ok;
    sel = int'(trk_sel);
    ok = sel < TRACKS;
    m_end = 0;
    for (int t = 0; t < TRACKS; t++) m_play[t] = REST;
    case (m_state)
      0: begin
        m_beat = 0;
        if (clr_req) begin if (ok) m_len[sel] = 0; end
        else if (rec_req) m_state = 1;
        else if (edit_req) m_state = 4;
        else if (play_req) m_state = 2;
      end
      1: begin
        if (!rec_req) begin m_state = 0; m_beat = 0; end
        else begin
          for (int t = 0; t < TRACKS; t++)
            if (!(ok && t == sel) && m_beat < m_len[t]) m_play[t] = m_mem[t][m_beat];
          if (ok) begin
            m_mem[sel][m_beat] = int'(live_pitch);
            m_wr[sel][m_beat] = 1'b1;
            m_len[sel] = m_beat + 1;
          end
          if (m_beat == DEPTH - 1) begin m_state = 0; m_beat = 0; end
          else m_beat++;
        end
      end
      2: begin
        sl = m_song_len();
        if (!play_req) begin m_state = 0; m_beat = 0; end
        else if (sl == 0) m_state = 3;
        else begin
          for (int t = 0; t < TRACKS; t++)
            if (m_beat < m_len[t]) m_play[t] = m_mem[t][m_beat];
          if (m_beat == sl - 1) begin
            m_end = 1;
            if (loop_en) m_beat = 0; else m_state = 3;
          end else m_beat++;
        end
      end
      3: if (!play_req) begin m_state = 0; m_beat = 0; end
      default: begin
        if (!edit_req) begin m_state = 0; m_beat = 0; end
        else begin
          lim = ok ? m_len[sel] : 0;
          if (lim > DEPTH - 1) lim = DEPTH - 1;
          if (select && ok) begin
            m_mem[sel][m_beat] = m_cur;
            m_wr[sel][m_beat] = 1'b1;
            if (m_beat == m_len[sel]) m_len[sel]++;
          end
          if (dir[0] && !dir[1]) begin if (m_beat > 0) m_beat--; end
          else if (dir[1] && !dir[0]) begin if (m_beat < lim) m_beat++; end
          if (dir[2] && !dir[3]) begin if (m_cur > 0) m_cur--; end
          else if (dir[3] && !dir[2]) begin if (m_cur < MAX_PITCH) m_cur++; end
        end
      end
    endcase
  endtask

  task automatic beat();
    @(negedge clk);
    beat_tick = 1'b1;
    m_view_ok = 1'b0;
    if (int'(trk_sel) < TRACKS) begin
      m_view_ok = m_wr[trk_sel][view_addr];
      m_view = m_mem[trk_sel][view_addr];
    end
    model_tick();
    @(negedge clk);
    beat_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (beat_num !== '0) begin failures++; $display("FAIL reset_beat got %0d want 0", beat_num); end
    checks++; if (cur_pitch !== '0) begin failures++; $display("FAIL reset_cur got %0d want 0", cur_pitch); end
    checks++; if (song_len !== '0) begin failures++; $display("FAIL reset_len got %0d want 0", song_len); end
    checks++; if (play_pitch !== 12'hFFF) begin failures++; $display("FAIL reset_pp got %h want fff", play_pitch); end
    checks++; if (end_pulse !== 1'b0) begin failures++; $display("FAIL reset_end got %b want 0", end_pulse); end
  endtask

  task automatic test_record_play();
    int exp_p[3] = '{5, 7, 9};
    trk_sel = 3'd0; rec_req = 1'b1;
    beat();
    for (int i = 0; i < 3; i++) begin live_pitch = 6'(exp_p[i]); beat(); end
    rec_req = 1'b0;
    beat();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rec_idle got %0d want 0", state); end
    checks++; if (song_len !== 11'd3) begin failures++; $display("FAIL rec_len got %0d want 3", song_len); end
    play_req = 1'b1;
    beat();
    for (int i = 0; i < 3; i++) begin
      beat();
      checks++;
      if (play_pitch !== {6'd63, 6'(exp_p[i])}) begin
        failures++; $display("FAIL play_note%0d got %h want %h", i, play_pitch, {6'd63, 6'(exp_p[i])});
      end
      checks++;
      if (end_pulse !== (i == 2)) begin failures++; $display("FAIL play_end%0d got %b want %b", i, end_pulse, i == 2); end
    end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL play_stop got %0d want 3", state); end
    beat();
    checks++; if (play_pitch !== 12'hFFF) begin failures++; $display("FAIL stop_rest got %h want fff", play_pitch); end
    play_req = 1'b0;
    beat();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL stop_idle got %0d want 0", state); end
  endtask

  task automatic test_overdub_loop();
    logic [11:0] want[4] = '{{6'd12, 6'd5}, {6'd12, 6'd7}, {6'd63, 6'd9}, {6'd12, 6'd5}};
    trk_sel = 3'd1; rec_req = 1'b1; live_pitch = 6'd12;
    beat();
    beat();
    checks++; if (play_pitch !== {6'd63, 6'd5}) begin failures++; $display("FAIL odub_b0 got %h want %h", play_pitch, {6'd63, 6'd5}); end
    beat();
    checks++; if (play_pitch !== {6'd63, 6'd7}) begin failures++; $display("FAIL odub_b1 got %h want %h", play_pitch, {6'd63, 6'd7}); end
    rec_req = 1'b0;
    beat();
    checks++; if (song_len !== 11'd3) begin failures++; $display("FAIL odub_len got %0d want 3", song_len); end
    loop_en = 1'b1; play_req = 1'b1;
    beat();
    for (int i = 0; i < 4; i++) begin
      beat();
      checks++; if (play_pitch !== want[i]) begin failures++; $display("FAIL loop_note%0d got %h want %h", i, play_pitch, want[i]); end
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL loop_state%0d got %0d want 2", i, state); end
    end
    checks++; if (beat_num !== 10'd1) begin failures++; $display("FAIL loop_wrap got %0d want 1", beat_num); end
    play_req = 1'b0; loop_en = 1'b0;
    beat();
  endtask

  task automatic test_view();
    trk_sel = 3'd0; view_addr = 10'd1;
    repeat (2) @(negedge clk);
    checks++; if (view_pitch !== 6'd7) begin failures++; $display("FAIL view_a1 got %0d want 7", view_pitch); end
    view_addr = 10'd2;
    repeat (2) @(negedge clk);
    checks++; if (view_pitch !== 6'd9) begin failures++; $display("FAIL view_a2 got %0d want 9", view_pitch); end
  endtask

  task automatic test_edit();
    trk_sel = 3'd0; edit_req = 1'b1; dir = 4'b0000;
    beat();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL edit_enter got %0d want 4", state); end
    dir = 4'b0001;
    beat();
    checks++; if (beat_num !== 10'd0) begin failures++; $display("FAIL edit_left0 got %0d want 0", beat_num); end
    dir = 4'b1000;
    repeat (50) beat();
    checks++; if (cur_pitch !== 6'd47) begin failures++; $display("FAIL edit_up_clamp got %0d want 47", cur_pitch); end
    dir = 4'b0010;
    repeat (4) beat();
    checks++; if (beat_num !== 10'd3) begin failures++; $display("FAIL edit_right_clamp got %0d want 3", beat_num); end
    dir = 4'b0011;
    beat();
    checks++; if (beat_num !== 10'd3) begin failures++; $display("FAIL edit_both got %0d want 3", beat_num); end
    dir = 4'b0000; select = 1'b1;
    beat();
    select = 1'b0;
    checks++; if (song_len !== 11'd4) begin failures++; $display("FAIL edit_append got %0d want 4", song_len); end
    dir = 4'b0001;
    repeat (2) beat();
    dir = 4'b0100;
    repeat (3) beat();
    checks++; if (cur_pitch !== 6'd44) begin failures++; $display("FAIL edit_down got %0d want 44", cur_pitch); end
    dir = 4'b0000; view_addr = 10'd1; select = 1'b1;
    beat();
    select = 1'b0;
    checks++; if (view_pitch !== 6'd7) begin failures++; $display("FAIL view_collide_old got %0d want 7", view_pitch); end
    @(negedge clk);
    checks++; if (view_pitch !== 6'd44) begin failures++; $display("FAIL view_collide_new got %0d want 44", view_pitch); end
    edit_req = 1'b0;
    beat();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL edit_exit got %0d want 0", state); end
  endtask

  task automatic test_reset_mid_play();
    play_req = 1'b1;
    repeat (3) beat();
    @(negedge clk);
    reset = 1'b1; beat_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0; beat_tick = 1'b0; play_req = 1'b0;
    model_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rmid_state got %0d want 0", state); end
    checks++; if (play_pitch !== 12'hFFF) begin failures++; $display("FAIL rmid_pp got %h want fff", play_pitch); end
    checks++; if (song_len !== '0) begin failures++; $display("FAIL rmid_len got %0d want 0", song_len); end
  endtask

  task automatic test_depth();
    trk_sel = 3'd0; rec_req = 1'b1;
    beat();
    for (int i = 0; i < DEPTH; i++) begin
      live_pitch = 6'($urandom_range(0, 63));
      beat();
      if (i == DEPTH - 2) begin
        checks++; if (beat_num !== 10'd1023) begin failures++; $display("FAIL depth_last_addr got %0d want 1023", beat_num); end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL depth_still_rec got %0d want 1", state); end
      end
    end
    rec_req = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL depth_idle got %0d want 0", state); end
    checks++; if (song_len !== 11'd1024) begin failures++; $display("FAIL depth_len got %0d want 1024", song_len); end
    view_addr = 10'd1023;
    repeat (2) @(negedge clk);
    checks++;
    if (view_pitch !== 6'(m_mem[0][1023])) begin
      failures++; $display("FAIL depth_view got %0d want %0d", view_pitch, m_mem[0][1023]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) rec_req = ~rec_req;
      if ($urandom_range(0, 5) == 0) play_req = ~play_req;
      if ($urandom_range(0, 7) == 0) edit_req = ~edit_req;
      clr_req = ($urandom_range(0, 15) == 0);
      loop_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) trk_sel = 3'($urandom_range(0, 3));
      live_pitch = 6'($urandom_range(0, 63));
      dir = 4'($urandom_range(0, 15));
      select = ($urandom_range(0, 2) == 0);
      view_addr = 10'($urandom_range(0, 15));
      beat();
      checks++; if (state !== 3'(m_state)) begin failures++; $display("FAIL rnd_state @%0d got %0d want %0d", i, state, m_state); end
      checks++; if (beat_num !== 10'(m_beat)) begin failures++; $display("FAIL rnd_beat @%0d got %0d want %0d", i, beat_num, m_beat); end
      checks++; if (cur_pitch !== 6'(m_cur)) begin failures++; $display("FAIL rnd_cur @%0d got %0d want %0d", i, cur_pitch, m_cur); end
      checks++; if (song_len !== 11'(m_song_len())) begin failures++; $display("FAIL rnd_len @%0d got %0d want %0d", i, song_len, m_song_len()); end
      checks++; if (play_pitch !== m_pp()) begin failures++; $display("FAIL rnd_pp @%0d got %h want %h", i, play_pitch, m_pp()); end
      checks++; if (end_pulse !== 1'(m_end)) begin failures++; $display("FAIL rnd_end @%0d got %b want %0d", i, end_pulse, m_end); end
      if (m_view_ok) begin
        checks++; if (view_pitch !== 6'(m_view)) begin failures++; $display("FAIL rnd_view @%0d got %0d want %0d", i, view_pitch, m_view); end
      end
    end
  endtask

  initial begin
    for (int t = 0; t < TRACKS; t++)
      for (int a = 0; a < DEPTH; a++) begin m_mem[t][a] = 0; m_wr[t][a] = 1'b0; end
    model_reset();
    test_reset();
    test_record_play();
    test_overdub_loop();
    test_view();
    test_edit();
    test_reset_mid_play();
    test_depth();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
